// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state type and width helper for the scanning mux.
package mux_scan_pkg;
  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} mux_state_t;
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mux_scan_timer.sv
// mux_scan_timer: dwell counter and round-robin channel advance with wrap detect.
module mux_scan_timer import mux_scan_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int DWELL = 2,
  localparam int SELW = sel_width(CHANNELS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_run,
  input  logic            i_restart,
  input  logic            i_clear,
  input  logic [SELW-1:0] i_sel,
  output logic [SELW-1:0] o_sel_next,
  output logic            o_wrap
);
  localparam int CW = sel_width(DWELL);
  localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);
  localparam logic [SELW-1:0] LAST_SEL = SELW'(CHANNELS - 1);
  logic [CW-1:0] r_cnt, w_cnt;
  logic w_adv;
  // Scan entry counts from zero on the entry edge itself, so advances land DWELL edges later.
  always_comb begin
    w_cnt = i_restart ? '0 : r_cnt;
    w_adv = i_run && w_cnt == LAST_CNT;
    o_wrap = w_adv && i_sel == LAST_SEL;
    o_sel_next = !w_adv ? i_sel : (i_sel == LAST_SEL) ? '0 : i_sel + SELW'(1);
  end
  always_ff @(posedge clk)
    if (rst || i_clear) r_cnt <= '0;
    else if (i_run) r_cnt <= (w_cnt == LAST_CNT) ? '0 : w_cnt + CW'(1);
endmodule

// File: rtl/mux_scan_n.sv
// mux_scan_n: registered N-channel mux with manual load and timed round-robin scan.
module mux_scan_n import mux_scan_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL = 2,
  localparam int SELW = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      mode,
  input  logic                      load,
  input  logic [SELW-1:0]           sel_in,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]          data_out,
  output logic [SELW-1:0]           ch_out,
  output logic [SELW-1:0]           sel_out,
  output logic                      valid,
  output logic                      wrap,
  output logic                      err
);
  mux_state_t r_state, w_next;
  logic [SELW-1:0] r_sel, r_ch, w_sel_next;
  logic [WIDTH-1:0] r_data;
  logic r_valid, r_wrap, r_err;
  logic w_run, w_restart, w_clear, w_oob, w_load_ok, w_load_bad, w_wrap;
  logic [WIDTH-1:0] w_ch [CHANNELS];
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign w_ch[i] = data_in[i*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb
    w_next = !enable ? IDLE : mode ? SCAN : MANUAL;
  // Actions follow the state being entered on this edge, so valid tracks enable with one edge of delay.
  always_comb begin
    w_run = w_next == SCAN;
    w_restart = r_state != SCAN;
    w_clear = w_next == MANUAL;
    w_oob = {1'b0, sel_in} >= (SELW+1)'(CHANNELS);
    w_load_ok = w_clear && load && !w_oob;
    w_load_bad = w_clear && load && w_oob;
  end
  mux_scan_timer #(.CHANNELS(CHANNELS), .DWELL(DWELL)) u_timer (
    .clk(clk),
    .rst(rst),
    .i_run(w_run),
    .i_restart(w_restart),
    .i_clear(w_clear),
    .i_sel(r_sel),
    .o_sel_next(w_sel_next),
    .o_wrap(w_wrap)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_sel <= '0;
      r_data <= '0;
      r_ch <= '0;
      r_valid <= 1'b0;
      r_wrap <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_sel <= w_load_ok ? sel_in : w_sel_next;
      r_valid <= w_next != IDLE;
      r_wrap <= w_wrap;
      r_err <= w_load_bad;
      if (w_next != IDLE) begin
        r_data <= w_ch[r_sel];
        r_ch <= r_sel;
      end
    end
  assign data_out = r_data;
  assign ch_out = r_ch;
  assign sel_out = r_sel;
  assign valid = r_valid;
  assign wrap = r_wrap;
  assign err = r_err;
endmodule

// File: tb/tb_mux_scan_n.sv
// tb_mux_scan_n: directed vector table plus reset and out-of-range sequences.
module tb_mux_scan_n;
  logic clk = 0, rst, enable, mode, load;
  logic [1:0] sel_in;
  logic [15:0] data_in;
  logic [11:0] data_in3;
  logic [3:0] data_out, data_out3;
  logic [1:0] ch_out, sel_out, ch_out3, sel_out3;
  logic valid, wrap, err, valid3, wrap3, err3;
  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;
  assign data_in3 = data_in[11:0];

  mux_scan_n #(.WIDTH(4), .CHANNELS(4), .DWELL(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .load(load), .sel_in(sel_in),
    .data_in(data_in), .data_out(data_out), .ch_out(ch_out), .sel_out(sel_out),
    .valid(valid), .wrap(wrap), .err(err));

  mux_scan_n #(.WIDTH(4), .CHANNELS(3), .DWELL(2)) dut3 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .load(load), .sel_in(sel_in),
    .data_in(data_in3), .data_out(data_out3), .ch_out(ch_out3), .sel_out(sel_out3),
    .valid(valid3), .wrap(wrap3), .err(err3));

  typedef struct {
    logic en, md, ld;
    logic [1:0] sel;
    logic [3:0] data;
    logic [1:0] ch, so;
    logic vld, wr;
  } vec_t;
  vec_t v[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    v[0]  = '{1,0,1,2, 12,0,2,1,0};
    v[1]  = '{1,0,0,0,  9,2,2,1,0};
    v[2]  = '{1,0,1,0,  9,2,0,1,0};
    v[3]  = '{1,0,0,0, 12,0,0,1,0};
    v[4]  = '{1,1,0,0, 12,0,0,1,0};
    v[5]  = '{1,1,0,0, 12,0,1,1,0};
    v[6]  = '{1,1,0,0, 11,1,1,1,0};
    v[7]  = '{1,1,0,0, 11,1,2,1,0};
    v[8]  = '{1,1,0,0,  9,2,2,1,0};
    v[9]  = '{1,1,0,0,  9,2,3,1,0};
    v[10] = '{1,1,0,0, 14,3,3,1,0};
    v[11] = '{1,1,0,0, 14,3,0,1,1};
    v[12] = '{1,1,1,2, 12,0,0,1,0};
    v[13] = '{1,1,0,0, 12,0,1,1,0};
    v[14] = '{1,1,0,0, 11,1,1,1,0};
    v[15] = '{0,1,1,3, 11,1,1,0,0};
    v[16] = '{0,1,1,3, 11,1,1,0,0};
    v[17] = '{0,1,1,3, 11,1,1,0,0};
    v[18] = '{1,1,0,0, 11,1,1,1,0};
    v[19] = '{1,1,0,0, 11,1,2,1,0};
    v[20] = '{1,1,0,0,  9,2,2,1,0};
    v[21] = '{1,0,0,0,  9,2,2,1,0};
    v[22] = '{1,1,0,0,  9,2,2,1,0};
    v[23] = '{1,1,0,0,  9,2,3,1,0};
    v[24] = '{1,0,1,0, 14,3,0,1,0};

    rst = 1; enable = 1; mode = 0; load = 1; sel_in = 2;
    data_in = 16'hE9BC;
    step(); step();
    chk("rst_data", data_out, 0);
    chk("rst_sel", sel_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_err", err, 0);
    rst = 0;

    for (int k = 0; k < 25; k++) begin
      enable = v[k].en; mode = v[k].md; load = v[k].ld; sel_in = v[k].sel;
      step();
      chk($sformatf("v%0d_data", k), data_out, v[k].data);
      chk($sformatf("v%0d_ch", k), ch_out, v[k].ch);
      chk($sformatf("v%0d_sel", k), sel_out, v[k].so);
      chk($sformatf("v%0d_valid", k), valid, v[k].vld);
      chk($sformatf("v%0d_wrap", k), wrap, v[k].wr);
      chk($sformatf("v%0d_err", k), err, 0);
    end

    enable = 1; mode = 1; load = 0; sel_in = 0;
    step(); step(); step();
    chk("pre_rst_sel", sel_out, 1);
    rst = 1;
    step();
    chk("midrst_sel", sel_out, 0);
    chk("midrst_data", data_out, 0);
    chk("midrst_ch", ch_out, 0);
    chk("midrst_valid", valid, 0);
    rst = 0;
    step();
    chk("postrst_valid", valid, 1);
    chk("postrst_data", data_out, 12);
    chk("postrst_ch", ch_out, 0);

    mode = 0; load = 1; sel_in = 1;
    step();
    chk("oob_pre_sel", sel_out3, 1);
    chk("oob_pre_err", err3, 0);
    sel_in = 3;
    step();
    chk("oob_err", err3, 1);
    chk("oob_sel", sel_out3, 1);
    chk("inrange3_err", err, 0);
    chk("inrange3_sel", sel_out, 3);
    load = 0;
    step();
    chk("oob_err_drop", err3, 0);
    chk("oob_sel_hold", sel_out3, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
